// File: rtl/easy_axis_traffic_gen.sv
// AXI4-Stream traffic source: bursts of counter or PRBS words with a programmable
// burst length, burst count and inter-burst gap, fully honouring tready back-pressure.
module easy_axis_traffic_gen #(
  parameter int DWIDTH = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [31:0]       seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [LEN_W-1:0]  burst_num,
  input  logic [LEN_W-1:0]  gap_len,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       words_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Copies the 32-bit pattern word across the bus; upper copies are cut off at DWIDTH.
  function automatic logic [DWIDTH-1:0] f_rep(input logic [31:0] v);
    logic [DWIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      o[i] = v[i % 32];
    end
    return o;
  endfunction

  // Next pattern word: +1 counter, or Galois LFSR x^32+x^22+x^2+x+1 shifting right.
  function automatic logic [31:0] f_step(input logic m, input logic [31:0] v);
    logic [31:0] o;
    if (!m) begin
      o = v + 32'd1;
    end else if (v[0]) begin
      o = (v >> 1) ^ 32'h8020_0003;
    end else begin
      o = v >> 1;
    end
    return o;
  endfunction

  state_t            r_state;
  logic              r_mode;
  logic [LEN_W-1:0]  r_burst_len;
  logic [LEN_W-1:0]  r_burst_num;
  logic [LEN_W-1:0]  r_gap_len;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [LEN_W-1:0]  r_burst_cnt;
  logic [LEN_W-1:0]  r_gap_cnt;
  logic [31:0]       r_val;
  logic [DWIDTH-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_words;

  logic              w_accept;
  logic [31:0]       w_next_val;
  logic [31:0]       w_seed_val;
  logic              w_last_burst;
  logic [LEN_W-1:0]  w_beat_inc;

  assign w_accept     = r_tvalid & m_axis_tready;
  assign w_next_val   = f_step(r_mode, r_val);
  // An all-zero LFSR would lock up, so a zero PRBS seed is promoted to 1.
  assign w_seed_val   = (mode && (seed == 32'd0)) ? 32'd1 : seed;
  assign w_last_burst = (r_burst_cnt == (r_burst_num - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign w_beat_inc   = r_beat_cnt + {{(LEN_W-1){1'b0}}, 1'b1};

  // Run-control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_burst_len <= '0;
      r_burst_num <= '0;
      r_gap_len   <= '0;
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_val       <= 32'd0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_burst_len <= burst_len;
            r_burst_num <= burst_num;
            r_gap_len   <= gap_len;
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
            r_val       <= w_seed_val;
            r_tdata     <= f_rep(w_seed_val);
            r_words     <= 32'd0;
            r_busy      <= 1'b1;
            if ((burst_len == '0) || (burst_num == '0)) begin
              r_tlast <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_tlast  <= (burst_len == {{(LEN_W-1){1'b0}}, 1'b1});
              r_tvalid <= 1'b1;
              r_state  <= S_SEND;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_words <= r_words + 32'd1;
            r_val   <= w_next_val;
            r_tdata <= f_rep(w_next_val);
            if (r_tlast) begin
              r_beat_cnt  <= '0;
              r_burst_cnt <= r_burst_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
              if (w_last_burst) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_state  <= S_DONE;
              end else if (r_gap_len == '0) begin
                r_tlast <= (r_burst_len == {{(LEN_W-1){1'b0}}, 1'b1});
                r_state <= S_SEND;
              end else begin
                r_tlast   <= (r_burst_len == {{(LEN_W-1){1'b0}}, 1'b1});
                r_tvalid  <= 1'b0;
                r_gap_cnt <= r_gap_len;
                r_state   <= S_GAP;
              end
            end else begin
              r_beat_cnt <= w_beat_inc;
              r_tlast    <= (w_beat_inc == (r_burst_len - {{(LEN_W-1){1'b0}}, 1'b1}));
            end
          end else begin
            r_state <= S_SEND;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign words_sent    = r_words;

endmodule

// File: tb/tb_easy_axis_traffic_gen.sv
// Randomised bench for easy_axis_traffic_gen: each run is checked beat-by-beat against a
// queue of expected words built from the counter/LFSR rules, plus gap, latency and done checks.
module tb_easy_axis_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [15:0] burst_len = 16'd0;
  logic [15:0] burst_num = 16'd0;
  logic [15:0] gap_len = 16'd0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] cap[$];

  easy_axis_traffic_gen #(.DWIDTH(32), .LEN_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .seed          (seed),
    .burst_len     (burst_len),
    .burst_num     (burst_num),
    .gap_len       (gap_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .words_sent    (words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference pattern step written straight from the arithmetic definition.
  function automatic logic [31:0] ref_next(input logic m, input logic [31:0] v);
    if (!m) return v + 32'd1;
    if ((v % 32'd2) == 32'd1) return (v / 32'd2) ^ 32'h8020_0003;
    return v / 32'd2;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tdata"}, m_axis_tdata, 32'd0);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_words"}, words_sent, 32'd0);
  endtask

  task automatic run(input logic m, input logic [31:0] sd, input int bl, input int bn,
                     input int gl, input int ready_pct, input int poke_at, input int abort_at);
    logic [31:0] qd[$];
    logic        ql[$];
    logic [31:0] v;
    int          total;
    int          zc;
    bit          gap_pend;
    bit          seen_done;
    v = (m && sd == 32'd0) ? 32'd1 : sd;
    for (int b = 0; b < bn; b++) begin
      for (int w = 0; w < bl; w++) begin
        qd.push_back(v);
        ql.push_back(w == bl - 1);
        v = ref_next(m, v);
      end
    end
    total = qd.size();
    cap.delete();
    mode = m; seed = sd;
    burst_len = 16'(bl); burst_num = 16'(bn); gap_len = 16'(gl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (total > 0) chk("first_valid_latency", 32'(m_axis_tvalid), 32'd1);
    gap_pend = 1'b0; zc = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (cyc == abort_at) begin
        rst_n = 1'b0; m_axis_tready = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("abort");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_no_valid", 32'(m_axis_tvalid), 32'd0);
        return;
      end
      if (cyc == poke_at) begin
        start = 1'b1; seed = 32'hDEAD_BEEF; mode = ~m;
        burst_len = 16'd1; burst_num = 16'd1; gap_len = 16'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("words_sent", words_sent, 32'(total));
        chk("beats_remaining", 32'(qd.size()), 32'd0);
        if (total == 0) chk("empty_done_latency", 32'(cyc), 32'd1);
      end else if (m_axis_tvalid) begin
        if (qd.size() == 0) begin
          chk("extra_beat", 32'(m_axis_tvalid), 32'd0);
        end else begin
          if (gap_pend) begin
            chk("gap_cycles", 32'(zc), 32'(gl));
            gap_pend = 1'b0;
          end
          chk("tdata", m_axis_tdata, qd[0]);
          chk("tlast", 32'(m_axis_tlast), 32'(ql[0]));
          m_axis_tready = ($urandom_range(99) < ready_pct);
          if (m_axis_tready) begin
            cap.push_back(qd[0]);
            if (ql[0] && qd.size() > 1) begin
              gap_pend = 1'b1;
              zc = 0;
            end
            void'(qd.pop_front());
            void'(ql.pop_front());
          end
        end
      end else begin
        zc++;
        m_axis_tready = ($urandom_range(99) < ready_pct);
      end
      if (!seen_done) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!seen_done) chk("done_timeout", 32'(seen_done), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("words_hold", words_sent, 32'(total));
  endtask

  initial begin
    // Reset held over random inputs, then released with start low.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); mode = 1'($urandom); seed = $urandom;
      burst_len = 16'($urandom_range(5)); burst_num = 16'($urandom_range(5));
      m_axis_tready = 1'($urandom);
      @(posedge clk); #1;
    end
    chk_all_zero("reset");
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("post_reset");

    run(1'b0, 32'h10, 4, 2, 3, 100, -1, -1);
    run(1'b0, 32'h10, 4, 2, 3, 50, -1, -1);

    run(1'b1, 32'd0, 5, 2, 2, 70, -1, -1);
    if (cap.size() >= 2) begin
      chk("prbs_seed0_first", cap[0], 32'h0000_0001);
      chk("prbs_seed0_second", cap[1], 32'h8020_0003);
    end else begin
      chk("prbs_capture_len", 32'(cap.size()), 32'd10);
    end
    run(1'b1, 32'd1, 5, 2, 2, 70, -1, -1);

    run(1'b0, 32'd5, 0, 3, 1, 100, -1, -1);
    run(1'b0, 32'd5, 3, 0, 1, 100, -1, -1);
    run(1'b0, 32'd9, 3, 3, 0, 100, -1, -1);
    run(1'b0, 32'hFFFF_FFFE, 3, 1, 0, 100, -1, -1);

    run(1'b0, 32'd7, 6, 4, 2, 80, 4, -1);
    run(1'b1, 32'h1234_5678, 8, 3, 2, 60, -1, 5);
    run(1'b0, 32'h100, 2, 2, 1, 100, -1, -1);

    for (int r = 0; r < 6; r++) begin
      run(1'($urandom), $urandom, $urandom_range(1, 6), $urandom_range(1, 4),
          $urandom_range(0, 4), $urandom_range(30, 100), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
